// File: rtl/ro_freq_counter_pkg.sv
// ----------------------------------------------------------------------------
// ro_freq_counter_pkg
// Shared definitions for the ring-oscillator frequency counter:
//   - FSM state encoding (IDLE=0, SETTLE=1, COUNT=2, DONE=3)
//   - default parameter values shared with the ring-oscillator macro
//   - timerWidth(): width of the gate/settle down-counter
// ----------------------------------------------------------------------------
package ro_freq_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DONE   = 2'd3
    } roState_e;

    localparam int DEF_WINDOW_CYCLES = 32'sd1024;
    localparam int DEF_SETTLE_CYCLES = 32'sd16;
    localparam int DEF_SYNC_STAGES   = 32'sd2;
    localparam int DEF_COUNT_W       = 32'sd16;

    // clog2(max(window, settle)) with a floor of one bit; the timer only
    // ever holds load values of window-1 and settle-1.
    function automatic int timerWidth(input int window, input int settle);
        int maxVal;
        int width;
        int pow;
        maxVal = (window > settle) ? window : settle;
        width  = 32'sd0;
        pow    = 32'sd1;
        while (pow < maxVal) begin
            pow   = pow * 32'sd2;
            width = width + 32'sd1;
        end
        return (width < 32'sd1) ? 32'sd1 : width;
    endfunction

endpackage

// File: rtl/ro_freq_counter_osc_sync.sv
// ----------------------------------------------------------------------------
// osc_sync_edge
// Brings the free-running ring-oscillator output into the iClk domain and
// flags its rising edges.
//   iClk   : system clock (rising edge)
//   iRst   : synchronous active-high reset, clears every flop
//   iAsync : asynchronous oscillator output
//   oRise  : high for one cycle when the synchronised level goes 0 -> 1
// A rising edge is a 0 in the history flop followed by a 1 in the last
// synchroniser stage. Oscillators at or above iClk/2 alias.
// ----------------------------------------------------------------------------
module osc_sync_edge
    import ro_freq_counter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iAsync,
    output logic oRise
);

    // First stage may go metastable; keep it paired with the next stage.
    (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic meta_r;
    (* dont_touch = "true" *) logic [SYNC_STAGES-1:1] chain_r;
    logic history_r;

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            meta_r    <= 1'b0;
            chain_r   <= '0;
            history_r <= 1'b0;
        end else begin
            meta_r     <= iAsync;
            chain_r[1] <= meta_r;
            for (int i = 2; i < SYNC_STAGES; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
            history_r <= chain_r[SYNC_STAGES-1];
        end
    end

    assign oRise = chain_r[SYNC_STAGES-1] & ~history_r;

endmodule

// File: rtl/ro_freq_counter.sv
// ----------------------------------------------------------------------------
// ro_freq_counter
// Enables the ring oscillator, lets it settle, counts its rising edges over
// a fixed window of iClk cycles and reports a saturating registered count.
//   iClk      : system clock (rising edge)
//   iRst      : synchronous active-high reset; aborts any measurement
//   iStart    : measurement request, sampled only in IDLE
//   iOsc      : asynchronous ring-oscillator output
//   oRoEn     : oscillator enable, high in SETTLE and COUNT
//   oBusy     : high in SETTLE and COUNT
//   oDone     : one-cycle pulse in DONE, when oCount/oOverflow update
//   oCount    : last measured edge count (saturating)
//   oOverflow : last measurement saturated
// Latency: iStart at cycle t -> SETTLE t+1, COUNT t+1+SETTLE_CYCLES,
// oDone at t+1+SETTLE_CYCLES+WINDOW_CYCLES.
// ----------------------------------------------------------------------------
module ro_freq_counter
    import ro_freq_counter_pkg::*;
#(
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int COUNT_W       = DEF_COUNT_W
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iStart,
    input  logic               iOsc,
    output logic               oRoEn,
    output logic               oBusy,
    output logic               oDone,
    output logic [COUNT_W-1:0] oCount,
    output logic               oOverflow
);

    localparam int TIMER_W = timerWidth(WINDOW_CYCLES, SETTLE_CYCLES);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 32'sd1);
    localparam logic [TIMER_W-1:0] WINDOW_LOAD = TIMER_W'(WINDOW_CYCLES - 32'sd1);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(32'd1);
    localparam logic [COUNT_W-1:0] CNT_ONE     = COUNT_W'(32'd1);
    localparam logic [COUNT_W-1:0] CNT_MAX     = '1;

    roState_e           state_r;
    roState_e           nextState_s;
    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timerNext_s;
    logic [COUNT_W-1:0] edgeCnt_r;
    logic [COUNT_W-1:0] edgeCntNext_s;
    logic               sat_r;
    logic               satNext_s;
    logic               rise_s;
    logic               roEn_r;
    logic               busy_r;
    logic               done_r;
    logic [COUNT_W-1:0] count_r;
    logic               overflow_r;

    osc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) uOscSync (
        .iClk   (iClk),
        .iRst   (iRst),
        .iAsync (iOsc),
        .oRise  (rise_s)
    );

    // Next-state, timer and saturating edge-counter logic.
    always_comb begin
        nextState_s   = state_r;
        timerNext_s   = timer_r;
        edgeCntNext_s = edgeCnt_r;
        satNext_s     = sat_r;
        case (state_r)
            ST_IDLE: begin
                if (iStart) begin
                    nextState_s   = ST_SETTLE;
                    timerNext_s   = SETTLE_LOAD;
                    edgeCntNext_s = '0;
                    satNext_s     = 1'b0;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                edgeCntNext_s = '0;
                satNext_s     = 1'b0;
                if (timer_r == '0) begin
                    nextState_s = ST_COUNT;
                    timerNext_s = WINDOW_LOAD;
                end else begin
                    timerNext_s = timer_r - TIMER_ONE;
                end
            end
            ST_COUNT: begin
                // An edge seen in the final COUNT cycle still lands in the
                // result, because DONE captures the next-value terms.
                if (rise_s) begin
                    if (edgeCnt_r == CNT_MAX) begin
                        satNext_s = 1'b1;
                    end else begin
                        edgeCntNext_s = edgeCnt_r + CNT_ONE;
                    end
                end else begin
                    edgeCntNext_s = edgeCnt_r;
                end
                if (timer_r == '0) begin
                    nextState_s = ST_DONE;
                end else begin
                    timerNext_s = timer_r - TIMER_ONE;
                end
            end
            ST_DONE: begin
                nextState_s = ST_IDLE;
            end
            default: begin
                nextState_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, timer and edge counter registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r   <= ST_IDLE;
            timer_r   <= '0;
            edgeCnt_r <= '0;
            sat_r     <= 1'b0;
        end else begin
            state_r   <= nextState_s;
            timer_r   <= timerNext_s;
            edgeCnt_r <= edgeCntNext_s;
            sat_r     <= satNext_s;
        end
    end

    // Registered outputs decoded from the next state so they align with it.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            roEn_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            roEn_r <= (nextState_s == ST_SETTLE) || (nextState_s == ST_COUNT);
            busy_r <= (nextState_s == ST_SETTLE) || (nextState_s == ST_COUNT);
            done_r <= (nextState_s == ST_DONE);
            if (nextState_s == ST_DONE) begin
                count_r    <= edgeCntNext_s;
                overflow_r <= satNext_s;
            end else begin
                count_r    <= count_r;
                overflow_r <= overflow_r;
            end
        end
    end

    assign oRoEn     = roEn_r;
    assign oBusy     = busy_r;
    assign oDone     = done_r;
    assign oCount    = count_r;
    assign oOverflow = overflow_r;

endmodule

// File: tb/tb_ro_freq_counter.sv
// ----------------------------------------------------------------------------
// tb_ro_freq_counter
// Two instances (COUNT_W=16 and COUNT_W=4) share one stimulus stream.
// The model tracks measurements as (start cycle, done cycle) pairs and counts
// 0->1 transitions of the driven oscillator samples, delayed by the
// synchroniser depth, over the COUNT window.
// ----------------------------------------------------------------------------
module tb_ro_freq_counter;

    localparam int W    = 64;
    localparam int S    = 4;
    localparam int SYNC = 2;
    localparam int LAST = 1075;

    logic        clk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic        iOsc;
    logic        aRoEn, aBusy, aDone, aOvf;
    logic [15:0] aCount;
    logic        bRoEn, bBusy, bDone, bOvf;
    logic [3:0]  bCount;

    int cyc = -1;
    int nChecks = 0;
    int nPass = 0;

    bit oscHist   [0:2047];
    bit startHist [0:2047];
    bit rstHist   [0:2047];
    bit startPlan [0:2047];
    bit rstPlan   [0:2047];

    always #5 clk = ~clk;

    ro_freq_counter #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .SYNC_STAGES(SYNC), .COUNT_W(16)) dutA (
        .iClk(clk), .iRst(iRst), .iStart(iStart), .iOsc(iOsc),
        .oRoEn(aRoEn), .oBusy(aBusy), .oDone(aDone), .oCount(aCount), .oOverflow(aOvf)
    );

    ro_freq_counter #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .SYNC_STAGES(SYNC), .COUNT_W(4)) dutB (
        .iClk(clk), .iRst(iRst), .iStart(iStart), .iOsc(iOsc),
        .oRoEn(bRoEn), .oBusy(bBusy), .oDone(bDone), .oCount(bCount), .oOverflow(bOvf)
    );

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // Reference model and per-cycle comparison.
    int  mStart = -1;
    int  mDone  = -1;
    int  eCntA = 0, eCntB = 0;
    bit  eOvfA = 0, eOvfB = 0;
    always @(negedge clk) begin
        bit active, eBusy, eDone;
        int edges;
        if (cyc >= 0) begin
            active = (mDone >= 0) && (cyc > mStart) && (cyc <= mDone);
            eBusy  = active && (cyc < mDone);
            eDone  = active && (cyc == mDone);
            if (eDone) begin
                edges = 0;
                for (int k = mStart + 1 + S; k <= mStart + S + W; k++) begin
                    if (!oscHist[k-SYNC-1] && oscHist[k-SYNC]) edges++;
                end
                eCntA = (edges > 65535) ? 65535 : edges;
                eOvfA = (edges > 65535);
                eCntB = (edges > 15) ? 15 : edges;
                eOvfB = (edges > 15);
            end
            check("A.roEn", int'(aRoEn), int'(eBusy));
            check("A.busy", int'(aBusy), int'(eBusy));
            check("A.done", int'(aDone), int'(eDone));
            check("A.count", int'(aCount), eCntA);
            check("A.ovf", int'(aOvf), int'(eOvfA));
            check("B.roEn", int'(bRoEn), int'(eBusy));
            check("B.busy", int'(bBusy), int'(eBusy));
            check("B.done", int'(bDone), int'(eDone));
            check("B.count", int'(bCount), eCntB);
            check("B.ovf", int'(bOvf), int'(eOvfB));
            // Advance the model with this cycle's inputs.
            if (rstHist[cyc]) begin
                mStart = -1; mDone = -1;
                eCntA = 0; eCntB = 0; eOvfA = 0; eOvfB = 0;
            end else if (startHist[cyc] && !active) begin
                mStart = cyc;
                mDone  = cyc + 1 + S + W;
            end
        end
    end

    // Directed stimulus plus hand-computed literal expectations.
    initial begin
        bit o;
        bit jitVal;
        int jitLeft;
        iRst = 1'b1; iStart = 1'b0; iOsc = 1'b0;
        jitVal = 1'b0; jitLeft = 1;
        for (int c = 0; c < 2048; c++) begin
            startPlan[c] = 1'b0; rstPlan[c] = 1'b0;
            oscHist[c] = 1'b0; startHist[c] = 1'b0; rstHist[c] = 1'b0;
        end
        rstPlan[0] = 1'b1; rstPlan[1] = 1'b1; rstPlan[2] = 1'b1; rstPlan[730] = 1'b1;
        startPlan[10] = 1'b1;  startPlan[90] = 1'b1;  startPlan[170] = 1'b1;
        startPlan[246] = 1'b1; startPlan[321] = 1'b1;
        for (int c = 396; c <= 605; c++) startPlan[c] = 1'b1;
        startPlan[610] = 1'b1; startPlan[613] = 1'b1; startPlan[650] = 1'b1; startPlan[679] = 1'b1;
        startPlan[700] = 1'b1; startPlan[780] = 1'b1;
        for (int c = 856; c <= 1065; c++) startPlan[c] = 1'b1;

        for (int c = 0; c <= LAST; c++) begin
            @(posedge clk);
            #1;
            if (c < 90)        o = ((c % 4) >= 2);
            else if (c < 166)  o = 1'b0;
            else if (c < 246)  o = 1'b1;
            else if (c < 321)  o = ((c % 2) == 1);
            else if (c < 396)  o = ((c % 8) >= 4);
            else if (c < 856)  o = ((c % 4) >= 2);
            else begin
                jitLeft--;
                if (jitLeft == 0) begin
                    jitVal  = ~jitVal;
                    jitLeft = jitVal ? 2 : int'($urandom_range(3, 1));
                end
                o = jitVal;
            end
            iOsc = o; iStart = startPlan[c]; iRst = rstPlan[c];
            oscHist[c] = o; startHist[c] = startPlan[c]; rstHist[c] = rstPlan[c];
            cyc = c;
            @(negedge clk);
            #1;
            case (c)
                3:   begin check("lit.rst.roEn", int'(aRoEn), 0); check("lit.rst.count", int'(aCount), 0);
                           check("lit.rst.done", int'(aDone), 0); end
                10:  check("lit.c10.roEn", int'(aRoEn), 0);
                11:  begin check("lit.c11.roEn", int'(aRoEn), 1); check("lit.c11.busy", int'(aBusy), 1); end
                78:  check("lit.c78.busy", int'(aBusy), 1);
                79:  begin check("lit.c79.done", int'(aDone), 1); check("lit.c79.count", int'(aCount), 16);
                           check("lit.c79.ovf", int'(aOvf), 0); check("lit.c79.busy", int'(aBusy), 0);
                           check("lit.c79.roEn", int'(aRoEn), 0); end
                80:  check("lit.c80.done", int'(aDone), 0);
                159: check("lit.osc0.count", int'(aCount), 0);
                239: check("lit.osc1.count", int'(aCount), 0);
                315: begin check("lit.p2.countA", int'(aCount), 32); check("lit.p2.countB", int'(bCount), 15);
                           check("lit.p2.ovfB", int'(bOvf), 1); end
                390: begin check("lit.p8.countB", int'(bCount), 8); check("lit.p8.ovfB", int'(bOvf), 0);
                           check("lit.p8.countA", int'(aCount), 8); end
                465: check("lit.rep1.done", int'(aDone), 1);
                534: check("lit.rep2.early", int'(aDone), 0);
                535: check("lit.rep2.done", int'(aDone), 1);
                605: check("lit.rep3.done", int'(aDone), 1);
                679: check("lit.ign.done", int'(aDone), 1);
                680: check("lit.ign.noDone", int'(aDone), 0);
                681: check("lit.ign.busy", int'(aBusy), 0);
                731: begin check("lit.abort.roEn", int'(aRoEn), 0); check("lit.abort.busy", int'(aBusy), 0);
                           check("lit.abort.count", int'(aCount), 0); end
                769: check("lit.abort.noDone", int'(aDone), 0);
                849: begin check("lit.fresh.done", int'(aDone), 1); check("lit.fresh.count", int'(aCount), 16); end
                default: ;
            endcase
        end
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
